// File: rtl/reg_status_table.sv
// Register result-status table: tracks which reservation-station tag will write
// each architectural register, cleared by CDB broadcasts, with CDB-bypassed lookups.
module reg_status_table #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             flush,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic             rs_busy,
  output logic [TAG_W-1:0] rs_tag,
  output logic             rt_busy,
  output logic [TAG_W-1:0] rt_tag,
  output logic [5:0]       pending_cnt
);

  localparam int unsigned N_REGS = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 6;

  logic [N_REGS-1:0]             busy_q, busy_d;
  logic [N_REGS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]              pending_cnt_q, pending_cnt_d;

  // Next state: CDB clear first, then issue overrides it, flush overrides both.
  always_comb begin
    busy_d        = busy_q;
    tag_d         = tag_q;
    pending_cnt_d = '0;
    for (int i = 1; i < N_REGS; i++) begin
      if (cdb_valid && busy_q[i] && (tag_q[i] == cdb_tag)) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = '0;
      end
      if (issue_en && (issue_rd == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
        tag_d[i]  = issue_tag;
      end
    end
    if (flush) begin
      busy_d = '0;
      tag_d  = '0;
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
    for (int i = 0; i < N_REGS; i++) begin
      pending_cnt_d = pending_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      tag_q         <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      tag_q         <= tag_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // Source lookups from current state; a matching broadcast reads as already done.
  always_comb begin
    rs_busy = busy_q[rs_addr] && !(cdb_valid && (tag_q[rs_addr] == cdb_tag));
    rt_busy = busy_q[rt_addr] && !(cdb_valid && (tag_q[rt_addr] == cdb_tag));
    rs_tag  = rs_busy ? tag_q[rs_addr] : '0;
    rt_tag  = rt_busy ? tag_q[rt_addr] : '0;
  end

  assign pending_cnt = pending_cnt_q;

endmodule
